// File: rtl/window_3x3_gen_if.sv
// Pixel-stream / window-stream bundle for window_3x3_gen.
// Widths of win_row/win_col follow the frame geometry parameters.
interface window_3x3_gen_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
);
    logic [7:0]                 pix_in;
    logic                       pix_valid;
    logic                       sof;
    logic [71:0]                window;
    logic                       win_valid;
    logic [$clog2(IMG_H)-1:0]   win_row;
    logic [$clog2(IMG_W)-1:0]   win_col;
    logic                       frame_done;

    modport slave (
        input  pix_in, pix_valid, sof,
        output window, win_valid, win_row, win_col, frame_done
    );

    modport master (
        output pix_in, pix_valid, sof,
        input  window, win_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a shifting
// 3x3 register, emitting only fully-interior windows of a raster frame.
module window_3x3_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic            clk,
    input  logic            rst,
    window_3x3_gen_if.slave s
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    logic [71:0]   win_reg;

    logic          acc;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [7:0]    lb1_rd;
    logic [7:0]    lb2_rd;
    logic [71:0]   nxt_win;
    logic          qual;
    logic          last_pix;

    always_comb begin
        acc      = s.pix_valid && !rst;
        cur_col  = s.sof ? '0 : col;
        cur_row  = s.sof ? '0 : row;
        lb1_rd   = lb1[cur_col];
        lb2_rd   = lb2[cur_col];
        // Each row shifts left; the new right column is {row r-2, row r-1, current}.
        nxt_win  = {win_reg[63:56], win_reg[55:48], lb2_rd,
                    win_reg[39:32], win_reg[31:24], lb1_rd,
                    win_reg[15:8],  win_reg[7:0],   s.pix_in};
        qual     = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    end

    // Line buffers are not reset; row/column gating keeps stale bytes hidden.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= s.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            win_reg      <= '0;
            s.window     <= '0;
            s.win_valid  <= 1'b0;
            s.win_row    <= '0;
            s.win_col    <= '0;
            s.frame_done <= 1'b0;
        end else begin
            s.win_valid  <= qual;
            s.frame_done <= qual && last_pix && !s.sof;
            if (acc) begin
                win_reg <= nxt_win;
                if (cur_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
            end
            if (qual) begin
                s.window  <= nxt_win;
                s.win_row <= cur_row - RW'(1);
                s.win_col <= cur_col - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 5x5 frame with pixel = base + 5r + c + 1.
module tb_window_3x3_gen;
    localparam int W = 5;
    localparam int H = 5;

    typedef struct {
        int          r;
        int          c;
        logic [71:0] win;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   win_cnt = 0;
    logic [71:0] last_win = '0;
    vec_t tbl [9];

    window_3x3_gen_if #(.IMG_W(W), .IMG_H(H)) bus ();
    window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .s(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_window"}, bus.window, 72'h0);
        chk({name, "_win_valid"}, 72'(bus.win_valid), 72'h0);
        chk({name, "_win_row"}, 72'(bus.win_row), 72'h0);
        chk({name, "_win_col"}, 72'(bus.win_col), 72'h0);
        chk({name, "_frame_done"}, 72'(bus.frame_done), 72'h0);
    endtask

    task automatic send(input int r, input int c, input int base, input bit s);
        int k;
        logic [71:0] exp;
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'(base + 5 * r + c + 1);
        bus.sof       = s;
        @(posedge clk);
        #1;
        if (r >= 2 && c >= 2) begin
            k   = (r - 2) * 3 + (c - 2);
            exp = tbl[k].win + {9{8'(base)}};
            chk("win_valid", 72'(bus.win_valid), 72'h1);
            chk("window", bus.window, exp);
            chk("win_row", 72'(bus.win_row), 72'(tbl[k].r));
            chk("win_col", 72'(bus.win_col), 72'(tbl[k].c));
            last_win = exp;
            if (bus.win_valid === 1'b1) win_cnt++;
        end else begin
            chk("win_valid_masked", 72'(bus.win_valid), 72'h0);
        end
        chk("frame_done", 72'(bus.frame_done), 72'((r == H - 1 && c == W - 1) ? 1 : 0));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = 1'($urandom_range(0, 1));
        bus.pix_in    = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        chk("idle_win_valid", 72'(bus.win_valid), 72'h0);
        chk("idle_frame_done", 72'(bus.frame_done), 72'h0);
        chk("idle_window_hold", bus.window, last_win);
    endtask

    task automatic send_frame(input int base, input bit sof_first, input bit throttle);
        win_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (throttle) begin
                    for (int g = 0; g < 4; g++) begin
                        if ($urandom_range(0, 1) == 0) break;
                        idle();
                    end
                end
                send(r, c, base, sof_first && r == 0 && c == 0);
            end
        end
        chk("win_count", 72'(win_cnt), 72'd9);
    endtask

    task automatic do_reset(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pix_in    = 8'($urandom_range(0, 255));
            bus.sof       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            chk_zero_outputs("in_reset");
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        @(posedge clk);
        #1;
        chk_zero_outputs("after_reset");
        last_win = '0;
    endtask

    initial begin
        tbl[0] = '{1, 1, 72'h010203_060708_0B0C0D};
        tbl[1] = '{1, 2, 72'h020304_07080_90C0D0E};
        tbl[2] = '{1, 3, 72'h030405_08090A_0D0E0F};
        tbl[3] = '{2, 1, 72'h060708_0B0C0D_101112};
        tbl[4] = '{2, 2, 72'h070809_0C0D0E_111213};
        tbl[5] = '{2, 3, 72'h08090A_0D0E0F_121314};
        tbl[6] = '{3, 1, 72'h0B0C0D_101112_151617};
        tbl[7] = '{3, 2, 72'h0C0D0E_111213_161718};
        tbl[8] = '{3, 3, 72'h0D0E0F_121314_171819};

        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'h00;
        bus.sof       = 1'b0;

        // Reset with random activity on the inputs
        do_reset(2, 1'b1);

        // Continuous frame, then a throttled one
        send_frame(0, 1'b1, 1'b0);
        idle();
        send_frame(0, 1'b1, 1'b1);
        idle();

        // Back-to-back frames, second without sof
        send_frame(0, 1'b1, 1'b0);
        send_frame(100, 1'b0, 1'b0);
        idle();

        // sof restart where (1,3) of the abandoned frame would have been
        for (int i = 0; i < 8; i++) send(i / W, i % W, 0, i == 0);
        send_frame(100, 1'b1, 1'b0);
        idle();

        // sof restart late in a frame, after windows have already been produced
        for (int i = 0; i < 18; i++) send(i / W, i % W, 0, i == 0);
        send_frame(100, 1'b1, 1'b1);
        idle();

        // Mid-frame reset after 17 pixels; next frame has no sof
        for (int i = 0; i < 17; i++) send(i / W, i % W, 0, i == 0);
        do_reset(1, 1'b0);
        send_frame(0, 1'b0, 1'b0);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3×3 sliding-window generator that sits directly upstream of the 3×3 convolution block. It accepts a raster-order 8-bit pixel stream and buffers two previous image rows internally. Each cycle it can emit one 72-bit packed window in the same byte order the convolution block expects on its `img` input. Only fully-interior windows are produced; there is no padding, so a W×H frame yields (W-2)×(H-2) windows.

## Interface
- `IMG_W`, default 8: pixels per row. Minimum 3.
- `IMG_H`, default 8: rows per frame. Minimum 3.
- `clk`  input  1: single clock; all logic is rising-edge.
- `rst`  input  1: synchronous, active-high reset.
- `pix_in`  input  8: incoming pixel.
- `pix_valid`  input  1: `pix_in` is accepted on any rising edge where this is high. There is no backpressure.
- `sof`  input  1: start of frame. Sampled only with `pix_valid`; the accepted pixel becomes (row 0, col 0).
- `window`  output  72: packed 3×3 window.
  - `[71:64]` = top-left, `[63:56]` = top-middle, … , `[7:0]` = bottom-right.
  - Row-major; the top row is the oldest row.
- `win_valid`  output  1: `window` holds a new interior window. One-cycle pulse per qualifying accept.
- `win_row`  output  $clog2(IMG_H): row of the window centre.
- `win_col`  output  $clog2(IMG_W): column of the window centre.
- `frame_done`  output  1: one-cycle pulse, coincident with the last window of a frame.

## Operation
- **Counters.**
  - `col` runs 0..IMG_W-1; `row` runs 0..IMG_H-1. Both advance only on an accept.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1) both wrap to 0.
  - An accept with `sof`=1 is treated as (0,0). The counters then become (0,1).
- **Line buffers.**
  - Two IMG_W-deep 8-bit buffers, indexed by `col`. `lb1` holds row r-1 and `lb2` holds row r-2.
  - On an accept at column c: read `lb2[c]` and `lb1[c]`, then write `lb2[c]` ← old `lb1[c]` and `lb1[c]` ← `pix_in`. The reads return pre-write values.
  - Contents are not reset. Stale data is never exposed because of the row gating below.
- **Window register.**
  - A 3×3 register array. On an accept, every row shifts left by one column.
  - The new right column is {top: `lb2[c]`, middle: `lb1[c]`, bottom: `pix_in`}.
  - The register holds its value when there is no accept.
- **Qualification.**
  - An accept at (r,c) with r≥2 and c≥2 sets `win_valid`=1 on the next cycle. In that cycle, `win_row`=r-1 and `win_col`=c-1.
  - Columns 0 and 1 of every row are never flagged. This masks the window columns left over from the previous row.
- **Frame end.**
  - An accept at (IMG_H-1, IMG_W-1) that is not an `sof` pixel also sets `frame_done`=1 in the same cycle as its `win_valid`.
  - The next accept is (0,0) of the next frame, whether or not `sof` is asserted.
- **`sof` mid-frame.** The frame restarts at (0,0); `frame_done` is not pulsed for the abandoned frame.

## Timing
- Latency: `window`, `win_valid`, `win_row`, `win_col` and `frame_done` are all registered and valid 1 cycle after the qualifying accept edge.
- Throughput: one pixel per cycle sustained. Gaps in `pix_valid` are allowed anywhere, including mid-row and across row and frame boundaries.
- `win_valid` and `frame_done` are high for exactly one cycle per event. They are 0 in any cycle not immediately following an accept.
- `window`, `win_row` and `win_col` hold their last values while `win_valid`=0.
- Reset values:
  - `window`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `frame_done`=0.
  - `row`=`col`=0, window register cleared.
  - Applying reset mid-frame discards the partial frame, and the next accept is (0,0).
- `rst` takes priority over `pix_valid` in the same cycle; that pixel is dropped.

## Test plan
All scenarios use IMG_W=IMG_H=5 and pixel value = 5r+c+1 (1..25) unless stated.

1. **Reset.** Assert `rst` for 2 cycles with random `pix_valid`/`pix_in` -> all outputs are 0 during reset and on the first cycle after it.
2. **Continuous frame.** Send 25 pixels back-to-back, `sof` on the first ->
   - exactly 9 `win_valid` pulses;
   - first pulse 1 cycle after pixel 13 is accepted, with `window`=0x010203_060708_0B0C0D and `win_row`=`win_col`=1;
   - last pulse has `window`=0x0D0E0F_121314_171819 and `win_row`=`win_col`=3, with `frame_done`=1 in the same cycle.
3. **Throttled input.** Same frame with a random 50% `pix_valid` duty -> identical 9-window sequence, each window 1 cycle after its accept, and no spurious pulses.
4. **Back-to-back frames.** Send two frames with no idle between them; the second frame uses values 101..125 and has no `sof` -> the second frame's first window is 0x656667_6A6B6C_6F7071. No first-frame byte ever appears in a second-frame window.
5. **`sof` restart.** Pulse `sof` on the pixel at (1,3) of the first frame, then send a full frame -> `frame_done` is not pulsed for the abandoned frame; the next 9 windows match the new frame exactly.
6. **Mid-frame reset.** Assert `rst` for 1 cycle after 17 pixels, then send a full frame -> outputs are 0 after reset; the new frame produces exactly 9 correct windows and one `frame_done`.
